// File: rtl/share_memory_pkg.sv
// share_memory_pkg: shared-memory sizing defaults and port conflict detection
package share_memory_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int ADDR_WIDTH = 8;
    localparam int DEPTH      = 2 ** ADDR_WIDTH;

    // Two requests collide when they touch the same word and at least one writes.
    function automatic logic is_conflict(
        input logic pe_req,
        input logic pe_we,
        input logic [ADDR_WIDTH-1:0] pe_addr,
        input logic axi_req,
        input logic axi_we,
        input logic [ADDR_WIDTH-1:0] axi_addr
    );
        return pe_req && axi_req && (pe_addr == axi_addr) && (pe_we || axi_we);
    endfunction

endpackage

// File: rtl/share_memory_dpram.sv
// share_memory_dpram: two-port synchronous RAM with registered, holding read data
module share_memory_dpram #(
    parameter int DW = 32,
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          a_en,
    input  logic          a_we,
    input  logic [AW-1:0] a_addr,
    input  logic [DW-1:0] a_wdata,
    output logic [DW-1:0] a_rdata,
    input  logic          b_en,
    input  logic          b_we,
    input  logic [AW-1:0] b_addr,
    input  logic [DW-1:0] b_wdata,
    output logic [DW-1:0] b_rdata
);

    logic [DW-1:0] mem [2**AW];
    logic [DW-1:0] a_rdata_d, a_rdata_q, b_rdata_d, b_rdata_q;

    // Array has no reset; same-address dual writes never reach here (arbitrated above).
    always_ff @(posedge clk) begin
        if (a_en && a_we) mem[a_addr] <= a_wdata;
        if (b_en && b_we) mem[b_addr] <= b_wdata;
    end

    // Read data captures pre-edge contents on a granted read, otherwise holds.
    always_comb begin
        a_rdata_d = (a_en && !a_we) ? mem[a_addr] : a_rdata_q;
        b_rdata_d = (b_en && !b_we) ? mem[b_addr] : b_rdata_q;
    end

    // Read registers clear on reset so outputs are defined.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_rdata_q <= '0;
            b_rdata_q <= '0;
        end else begin
            a_rdata_q <= a_rdata_d;
            b_rdata_q <= b_rdata_d;
        end
    end

    assign a_rdata = a_rdata_q;
    assign b_rdata = b_rdata_q;

endmodule

// File: rtl/share_memory.sv
// share_memory: PE/AXI shared scratch memory with fixed PE priority on conflicts
module share_memory
    import share_memory_pkg::*;
#(
    parameter int DATA_WIDTH = share_memory_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = share_memory_pkg::ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  pe_request,
    input  logic                  pe_we,
    input  logic [ADDR_WIDTH-1:0] pe_addr,
    input  logic [DATA_WIDTH-1:0] pe_wdata,
    output logic [DATA_WIDTH-1:0] pe_rdata,
    output logic                  pe_grant,
    input  logic                  axi_request,
    input  logic                  axi_we,
    input  logic [ADDR_WIDTH-1:0] axi_addr,
    input  logic [DATA_WIDTH-1:0] axi_wdata,
    output logic [DATA_WIDTH-1:0] axi_rdata,
    output logic                  axi_grant
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic pe_en, axi_en;
    logic pe_grant_d, pe_grant_q, axi_grant_d, axi_grant_q;

    // PE always wins; enables are gated by reset so in-flight accesses are dropped.
    always_comb begin
        pe_en       = rst_n && pe_request;
        axi_en      = rst_n && axi_request &&
                      !is_conflict(pe_request, pe_we, pe_addr, axi_request, axi_we, axi_addr);
        pe_grant_d  = pe_en;
        axi_grant_d = axi_en;
    end

    // Grants report which port was served at the preceding edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pe_grant_q  <= 1'b0;
            axi_grant_q <= 1'b0;
        end else begin
            pe_grant_q  <= pe_grant_d;
            axi_grant_q <= axi_grant_d;
        end
    end

    assign pe_grant  = pe_grant_q;
    assign axi_grant = axi_grant_q;

    share_memory_dpram #(
        .DW(DATA_WIDTH),
        .AW($clog2(DEPTH))
    ) u_ram (
        .clk    (clk),
        .rst_n  (rst_n),
        .a_en   (pe_en),
        .a_we   (pe_we),
        .a_addr (pe_addr),
        .a_wdata(pe_wdata),
        .a_rdata(pe_rdata),
        .b_en   (axi_en),
        .b_we   (axi_we),
        .b_addr (axi_addr),
        .b_wdata(axi_wdata),
        .b_rdata(axi_rdata)
    );

endmodule

// File: tb/tb_share_memory.sv
// tb_share_memory: table-driven check of share_memory arbitration, data path and reset
module tb_share_memory;

    logic        clk, rst_n;
    logic        pe_request, pe_we, axi_request, axi_we;
    logic [7:0]  pe_addr, axi_addr;
    logic [31:0] pe_wdata, axi_wdata, pe_rdata, axi_rdata;
    logic        pe_grant, axi_grant;

    int applied = 0;
    int miscompares = 0;

    typedef struct {
        string       name;
        logic        pr, pw;
        logic [7:0]  pa;
        logic [31:0] pd;
        logic        ar, aw;
        logic [7:0]  aa;
        logic [31:0] ad;
        logic        epg, eag;
        logic [31:0] epr, ear;
    } vec_t;

    vec_t tbl [17];

    share_memory dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pe_request (pe_request),
        .pe_we      (pe_we),
        .pe_addr    (pe_addr),
        .pe_wdata   (pe_wdata),
        .pe_rdata   (pe_rdata),
        .pe_grant   (pe_grant),
        .axi_request(axi_request),
        .axi_we     (axi_we),
        .axi_addr   (axi_addr),
        .axi_wdata  (axi_wdata),
        .axi_rdata  (axi_rdata),
        .axi_grant  (axi_grant)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic drive(input logic pr, pw, input logic [7:0] pa, input logic [31:0] pd,
                         input logic ar, aw, input logic [7:0] aa, input logic [31:0] ad);
        pe_request = pr; pe_we = pw; pe_addr = pa; pe_wdata = pd;
        axi_request = ar; axi_we = aw; axi_addr = aa; axi_wdata = ad;
    endtask

    task automatic check(input string name, input logic epg, eag, input logic [31:0] epr, ear);
        applied++;
        if (pe_grant !== epg || axi_grant !== eag || pe_rdata !== epr || axi_rdata !== ear) begin
            miscompares++;
            $display("FAIL %s: got pg=%b ag=%b prd=%h ard=%h, expected pg=%b ag=%b prd=%h ard=%h",
                     name, pe_grant, axi_grant, pe_rdata, axi_rdata, epg, eag, epr, ear);
        end
    endtask

    initial begin
        tbl[0]  = '{"idle",          0,0,8'h00,32'h0,        0,0,8'h00,32'h0,        0,0,32'h0,        32'h0};
        tbl[1]  = '{"pe_wr_10",      1,1,8'h10,32'h12345678, 0,0,8'h00,32'h0,        1,0,32'h0,        32'h0};
        tbl[2]  = '{"pe_rd_10",      1,0,8'h10,32'h0,        0,0,8'h00,32'h0,        1,0,32'h12345678, 32'h0};
        tbl[3]  = '{"pe_rd_axi_wr",  1,0,8'h10,32'h0,        1,1,8'h20,32'hAABBCCDD, 1,1,32'h12345678, 32'h0};
        tbl[4]  = '{"axi_rd_20",     0,0,8'h00,32'h0,        1,0,8'h20,32'h0,        0,1,32'h12345678, 32'hAABBCCDD};
        tbl[5]  = '{"both_wr_30",    1,1,8'h30,32'hDEADBEEF, 1,1,8'h30,32'hCAFEBABE, 1,0,32'h12345678, 32'hAABBCCDD};
        tbl[6]  = '{"axi_rd_30",     0,0,8'h00,32'h0,        1,0,8'h30,32'h0,        0,1,32'h12345678, 32'hDEADBEEF};
        tbl[7]  = '{"pe_rd_axi_wr_c",1,0,8'h30,32'h0,        1,1,8'h30,32'h11112222, 1,0,32'hDEADBEEF, 32'hDEADBEEF};
        tbl[8]  = '{"axi_retry_wr",  0,0,8'h00,32'h0,        1,1,8'h30,32'h11112222, 0,1,32'hDEADBEEF, 32'hDEADBEEF};
        tbl[9]  = '{"pe_rd_30_new",  1,0,8'h30,32'h0,        0,0,8'h00,32'h0,        1,0,32'h11112222, 32'hDEADBEEF};
        tbl[10] = '{"both_rd_same",  1,0,8'h30,32'h0,        1,0,8'h30,32'h0,        1,1,32'h11112222, 32'h11112222};
        tbl[11] = '{"both_wr_diff",  1,1,8'h40,32'h40404040, 1,1,8'h41,32'h41414141, 1,1,32'h11112222, 32'h11112222};
        tbl[12] = '{"cross_rd",      1,0,8'h41,32'h0,        1,0,8'h40,32'h0,        1,1,32'h41414141, 32'h40404040};
        tbl[13] = '{"pe_wr_axi_rd_c",1,1,8'h50,32'h00000005, 1,0,8'h50,32'h0,        1,0,32'h41414141, 32'h40404040};
        tbl[14] = '{"axi_rd_50",     0,0,8'h00,32'h0,        1,0,8'h50,32'h0,        0,1,32'h41414141, 32'h00000005};
        tbl[15] = '{"we_no_req",     0,1,8'h10,32'hFFFFFFFF, 0,1,8'h20,32'hFFFFFFFF, 0,0,32'h41414141, 32'h00000005};
        tbl[16] = '{"rd_10_20",      1,0,8'h10,32'h0,        1,0,8'h20,32'h0,        1,1,32'h12345678, 32'hAABBCCDD};

        rst_n = 1'b0;
        drive(0,0,8'h00,32'h0, 0,0,8'h00,32'h0);
        repeat (10) @(posedge clk);
        #1 check("in_reset", 0,0,32'h0,32'h0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1 check("post_reset_idle", 0,0,32'h0,32'h0);

        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            drive(tbl[i].pr, tbl[i].pw, tbl[i].pa, tbl[i].pd, tbl[i].ar, tbl[i].aw, tbl[i].aa, tbl[i].ad);
            @(posedge clk);
            #1 check(tbl[i].name, tbl[i].epg, tbl[i].eag, tbl[i].epr, tbl[i].ear);
        end

        @(negedge clk) drive(1,0,8'h30,32'h0, 1,0,8'h40,32'h0);
        @(posedge clk);
        #1 check("pre_reset_active", 1,1,32'h11112222,32'h40404040);
        #2 rst_n = 1'b0;
        #1 check("async_reset", 0,0,32'h0,32'h0);
        drive(1,1,8'h10,32'hBAD0BAD0, 1,1,8'h20,32'h0BAD0BAD);
        repeat (2) @(posedge clk);
        #1 check("reset_held_writes", 0,0,32'h0,32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1,0,8'h10,32'h0, 1,0,8'h20,32'h0);
        @(posedge clk);
        #1 check("readback_10_20", 1,1,32'h12345678,32'hAABBCCDD);
        @(negedge clk) drive(1,0,8'h30,32'h0, 1,0,8'h41,32'h0);
        @(posedge clk);
        #1 check("readback_30_41", 1,1,32'h11112222,32'h41414141);
        @(negedge clk) drive(0,0,8'h00,32'h0, 0,0,8'h00,32'h0);
        @(posedge clk);
        #1 check("idle_hold", 0,0,32'h11112222,32'h41414141);

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule
